// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes,
// data-memory wait freeze with timeout, and halt.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  id_reg1,
  input  logic [2:0]  id_reg2,
  input  logic        ex_read_mem,
  input  logic [2:0]  ex_regD,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_i,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halted,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_o
);

  // state    | meaning
  // RUN      | normal issue; hazards resolved combinationally
  // MEM_WAIT | pipeline frozen waiting on data memory
  // HALT     | stopped until reset (encoding 3 also behaves as HALT)
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] HALT     = 2'd2;

  logic [1:0] state, state_nxt;
  logic [3:0] wait_cnt;
  logic       mem_stall, load_use, run_mode, halt_act, timeout;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = ex_read_mem && ((ex_regD == id_reg1) || (ex_regD == id_reg2));
  // A memory release cycle is resolved like RUN, except a halt is not taken there.
  assign run_mode  = (state == RUN) || ((state == MEM_WAIT) && mem_ready);
  assign halt_act  = (state == RUN) && halt_i;
  assign timeout   = (state == MEM_WAIT) && !mem_ready && (wait_cnt == 4'hF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_stall)   state_nxt = MEM_WAIT;
        else if (halt_i) state_nxt = HALT;
      end
      MEM_WAIT: begin
        if (mem_ready)    state_nxt = RUN;
        else if (timeout) state_nxt = HALT;
      end
      default: state_nxt = HALT;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    halted      = state[1];
    state_o     = state;
    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      halted      = 1'b0;
    end else if (run_mode && !mem_stall) begin
      if (halt_act) begin
        mem_wb_en = 1'b1;
      end else if (branch_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      mem_err   <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      if ((state == RUN) && mem_stall)
        wait_cnt <= 4'd1;
      else if ((state == MEM_WAIT) && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + 4'd1;
      if (timeout)
        mem_err <= 1'b1;
      if (!pc_en && !state[1] && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard outputs, memory freeze/timeout,
// halt, asynchronous reset and stall counter saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_reg1, id_reg2, ex_regD;
  logic        ex_read_mem, branch_taken, mem_req, mem_ready, halt_i;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, halted, mem_err;
  logic [15:0] stall_cnt;
  logic [1:0]  state_o;
  logic [6:0]  ov;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] V_NORM   = 7'b11111_00;
  localparam logic [6:0] V_LU     = 7'b00111_01;
  localparam logic [6:0] V_BR     = 7'b11111_11;
  localparam logic [6:0] V_FREEZE = 7'b00000_00;
  localparam logic [6:0] V_HALT   = 7'b00001_00;
  localparam logic [6:0] V_RST    = 7'b00000_11;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .id_reg1(id_reg1), .id_reg2(id_reg2),
    .ex_read_mem(ex_read_mem), .ex_regD(ex_regD),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_i(halt_i),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign ov = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [2:0] r1, input logic [2:0] r2, input logic rm,
                        input logic [2:0] rd, input logic br, input logic mq,
                        input logic mr, input logic h);
    id_reg1 = r1; id_reg2 = r2; ex_read_mem = rm; ex_regD = rd;
    branch_taken = br; mem_req = mq; mem_ready = mr; halt_i = h;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_vec", {9'd0, ov}, {9'd0, V_RST});
    chk("rst_state", {14'd0, state_o}, 16'd0);
    chk("rst_stall", stall_cnt, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_err", {15'd0, mem_err}, 16'd0);
    cyc; cyc;
    chk("rst_hold_vec", {9'd0, ov}, {9'd0, V_RST});
    reset = 1'b0;

    // normal
    #2 chk("norm_vec", {9'd0, ov}, {9'd0, V_NORM});
    cyc;
    chk("norm_stall", stall_cnt, 16'd0);

    // load-use via id_reg2
    set_in(3'd0, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("lu2_vec", {9'd0, ov}, {9'd0, V_LU});
    cyc;
    chk("lu2_stall", stall_cnt, 16'd1);
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("lu_clear_vec", {9'd0, ov}, {9'd0, V_NORM});
    cyc;
    chk("lu_clear_stall", stall_cnt, 16'd1);

    // load-use on r0 via id_reg1
    set_in(3'd0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("lu_r0_vec", {9'd0, ov}, {9'd0, V_LU});
    cyc;
    chk("lu_r0_stall", stall_cnt, 16'd2);

    // no register match, and match without load
    set_in(3'd3, 3'd4, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("nomatch_vec", {9'd0, ov}, {9'd0, V_NORM});
    cyc;
    set_in(3'd5, 3'd4, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("noload_vec", {9'd0, ov}, {9'd0, V_NORM});
    cyc;
    chk("noload_stall", stall_cnt, 16'd2);

    // branch overrides load-use
    set_in(3'd0, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 chk("br_lu_vec", {9'd0, ov}, {9'd0, V_BR});
    cyc;
    chk("br_lu_stall", stall_cnt, 16'd2);

    // memory wait 3 cycles then release
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2 chk("mw_freeze_vec", {9'd0, ov}, {9'd0, V_FREEZE});
      cyc;
      chk("mw_state", {14'd0, state_o}, 16'd1);
    end
    mem_ready = 1'b1;
    #2 chk("mw_release_vec", {9'd0, ov}, {9'd0, V_NORM});
    cyc;
    chk("mw_release_state", {14'd0, state_o}, 16'd0);
    chk("mw_stall", stall_cnt, 16'd5);

    // held branch acted on at release
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 chk("mw2_freeze_vec", {9'd0, ov}, {9'd0, V_FREEZE});
    cyc;
    mem_ready = 1'b1;
    #2 chk("mw2_release_br_vec", {9'd0, ov}, {9'd0, V_BR});
    cyc;
    chk("mw2_state", {14'd0, state_o}, 16'd0);
    chk("mw2_stall", stall_cnt, 16'd6);

    // halt
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 chk("halt_vec", {9'd0, ov}, {9'd0, V_HALT});
    cyc;
    chk("halt_state", {14'd0, state_o}, 16'd2);
    chk("halt_halted", {15'd0, halted}, 16'd1);
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    #2 chk("halt_ignore_vec", {9'd0, ov}, {9'd0, V_FREEZE});
    cyc;
    chk("halt_stay", {14'd0, state_o}, 16'd2);
    chk("halt_stall", stall_cnt, 16'd7);
    #2 reset = 1'b1;
    #1;
    chk("halt_rst_state", {14'd0, state_o}, 16'd0);
    chk("halt_rst_halted", {15'd0, halted}, 16'd0);
    chk("halt_rst_stall", stall_cnt, 16'd0);
    cyc;
    reset = 1'b0;

    // timeout: 16 frozen cycles
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      #2 chk("to_freeze_vec", {9'd0, ov}, {9'd0, V_FREEZE});
      chk("to_err_early", {15'd0, mem_err}, 16'd0);
      cyc;
    end
    chk("to_err", {15'd0, mem_err}, 16'd1);
    chk("to_halted", {15'd0, halted}, 16'd1);
    chk("to_state", {14'd0, state_o}, 16'd2);
    chk("to_stall", stall_cnt, 16'd16);
    set_in(3'd1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 chk("to_ignore_vec", {9'd0, ov}, {9'd0, V_FREEZE});
    cyc;
    chk("to_err_sticky", {15'd0, mem_err}, 16'd1);
    chk("to_stall_hold", stall_cnt, 16'd16);
    #2 reset = 1'b1;
    #1 chk("to_rst_err", {15'd0, mem_err}, 16'd0);
    cyc;
    reset = 1'b0;

    // ready on the last allowed cycle wins over timeout
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (15) cyc;
    mem_ready = 1'b1;
    #2 chk("edge_release_vec", {9'd0, ov}, {9'd0, V_NORM});
    cyc;
    chk("edge_state", {14'd0, state_o}, 16'd0);
    chk("edge_err", {15'd0, mem_err}, 16'd0);
    chk("edge_stall", stall_cnt, 16'd15);

    // async reset mid MEM_WAIT
    mem_ready = 1'b0;
    cyc; cyc;
    chk("mwr_state", {14'd0, state_o}, 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("mwr_rst_state", {14'd0, state_o}, 16'd0);
    chk("mwr_rst_vec", {9'd0, ov}, {9'd0, V_RST});
    cyc;
    reset = 1'b0;
    set_in(3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("mwr_after_vec", {9'd0, ov}, {9'd0, V_NORM});
    cyc;

    // stall counter saturation
    set_in(3'd2, 3'd7, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65534) cyc;
    chk("sat_fffe", stall_cnt, 16'hFFFE);
    cyc;
    chk("sat_ffff", stall_cnt, 16'hFFFF);
    cyc; cyc;
    chk("sat_hold", stall_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
